// File: rtl/tx_serial_pkg.sv
// Shared definitions for the 7O1 serial transmit arbiter: FSM state encoding,
// frame geometry constants and the round-robin pointer advance helper.
package tx_serial_pkg;

    typedef enum logic [2:0] {
        INICIAL     = 3'd0,
        ESPERA      = 3'd1,
        PREPARACAO  = 3'd2,
        TRANSMISSAO = 3'd3,
        FINAL       = 3'd4
    } estado_t;

    // idle + start + 7 data + odd parity + stop
    localparam int FRAME_BITS = 11;
    localparam int ASCII_W    = 7;

    function automatic int proximo_ponteiro(input int atual, input int n_req);
        return (atual + 1) % n_req;
    endfunction

endpackage

// File: rtl/tx_serial_rr_arbitro.sv
// Combinational one-hot pick of the first active request, searching upward from the
// round-robin pointer with wrap. TX_ARB_PRIORIDADE_FIXA_EN selects fixed priority instead.
module tx_serial_rr_arbitro
    import tx_serial_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         i_req,
`ifndef TX_ARB_PRIORIDADE_FIXA_EN
    input  logic [$clog2(N_REQ)-1:0] i_ponteiro,
`endif
    output logic [N_REQ-1:0]         o_grant
);

    int   w_idx;
    logic w_achou;

    always_comb begin
        o_grant = '0;
        w_achou = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
`ifdef TX_ARB_PRIORIDADE_FIXA_EN
            w_idx = k;
`else
            w_idx = (int'(i_ponteiro) + k) % N_REQ;
`endif
            if (!w_achou && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_achou        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_serial_7o1_arbitro.sv
// Shares one 7O1 serial transmit datapath among N_REQ requesters: arbitration, baud timing
// and datapath strobes. Define TX_ARB_PRIORIDADE_FIXA_EN for fixed priority (lowest index wins).
module tx_serial_7o1_arbitro
    import tx_serial_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int TICKS_PER_BIT = 434,
    parameter int TICK_W        = 9
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [ASCII_W*N_REQ-1:0] i_dados,
    output logic [N_REQ-1:0]         o_grant,
    output logic [N_REQ-1:0]         o_pronto,
    output logic                     o_ocupado,
    output logic                     o_tx_zera,
    output logic                     o_tx_carrega,
    output logic                     o_tx_desloca,
    output logic                     o_tx_conta,
    output logic [ASCII_W-1:0]       o_tx_dados_ascii,
    input  logic                     i_tx_fim
);

    estado_t            r_estado;
    estado_t            w_proximo;
    logic [TICK_W-1:0]  r_baud;
    logic [N_REQ-1:0]   r_grant;
    logic [N_REQ-1:0]   w_escolha;
    logic [ASCII_W-1:0] r_dados;
    logic [ASCII_W-1:0] w_dados_escolha;
    logic               w_tick;

    assign w_tick = (r_baud == TICK_W'(TICKS_PER_BIT - 1));

`ifdef TX_ARB_PRIORIDADE_FIXA_EN
    tx_serial_rr_arbitro #(
        .N_REQ (N_REQ)
    ) u_arbitro (
        .i_req   (i_req),
        .o_grant (w_escolha)
    );
`else
    localparam int PTR_W = $clog2(N_REQ);

    logic [PTR_W-1:0] r_ponteiro;
    int               w_dono;

    tx_serial_rr_arbitro #(
        .N_REQ (N_REQ)
    ) u_arbitro (
        .i_req      (i_req),
        .i_ponteiro (r_ponteiro),
        .o_grant    (w_escolha)
    );

    always_comb begin
        w_dono = 0;
        for (int k = 0; k < N_REQ; k++) begin
            if (r_grant[k]) begin
                w_dono = k;
            end
        end
    end

    // The finishing owner drops to lowest priority; a reset abort restarts from requester 0.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_ponteiro <= '0;
        end else if (r_estado == FINAL) begin
            r_ponteiro <= PTR_W'(proximo_ponteiro(w_dono, N_REQ));
        end
    end
`endif

    always_comb begin
        w_dados_escolha = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_escolha[k]) begin
                w_dados_escolha = w_dados_escolha | i_dados[k*ASCII_W +: ASCII_W];
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_estado <= INICIAL;
        end else begin
            r_estado <= w_proximo;
        end
    end

    // Baud counter only runs while transmitting; every other state leaves it at zero.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_baud <= '0;
        end else if (r_estado == TRANSMISSAO && !w_tick) begin
            r_baud <= r_baud + 1'b1;
        end else begin
            r_baud <= '0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_grant <= '0;
            r_dados <= '0;
        end else if (r_estado == ESPERA && |i_req) begin
            r_grant <= w_escolha;
            r_dados <= w_dados_escolha;
        end else if (r_estado == FINAL) begin
            r_grant <= '0;
        end
    end

    // tx_fim takes precedence over the tick so a finished frame never sees a 12th shift.
    always_comb begin
        w_proximo    = r_estado;
        o_pronto     = '0;
        o_ocupado    = 1'b0;
        o_tx_zera    = 1'b0;
        o_tx_carrega = 1'b0;
        o_tx_desloca = 1'b0;
        o_tx_conta   = 1'b0;
        case (r_estado)
            INICIAL: begin
                w_proximo = ESPERA;
            end
            ESPERA: begin
                if (|i_req) begin
                    w_proximo = PREPARACAO;
                end
            end
            PREPARACAO: begin
                o_ocupado    = 1'b1;
                o_tx_zera    = 1'b1;
                o_tx_carrega = 1'b1;
                w_proximo    = TRANSMISSAO;
            end
            TRANSMISSAO: begin
                o_ocupado = 1'b1;
                if (i_tx_fim) begin
                    w_proximo = FINAL;
                end else if (w_tick) begin
                    o_tx_desloca = 1'b1;
                    o_tx_conta   = 1'b1;
                end
            end
            FINAL: begin
                o_ocupado = 1'b1;
                o_pronto  = r_grant;
                w_proximo = ESPERA;
            end
            default: begin
                w_proximo = INICIAL;
            end
        endcase
    end

    assign o_grant          = r_grant;
    assign o_tx_dados_ascii = r_dados;

endmodule

// File: tb/tb_tx_serial_7o1_arbitro.sv
// Bench for tx_serial_7o1_arbitro with a behavioural 7O1 datapath and a frame-level
// reference model derived from the protocol latencies (TICKS_PER_BIT=4, N_REQ=4).
module tb_tx_serial_7o1_arbitro;
    import tx_serial_pkg::*;

    localparam int N = 4;
    localparam int T = 4;
    // Offset of the pronto cycle from the ESPERA cycle that sampled the request.
    localparam int FRAME_CYCLES = 3 + FRAME_BITS * T;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic [N-1:0]         req   = '0;
    logic [ASCII_W*N-1:0] dados = '0;
    logic [N-1:0]         grant;
    logic [N-1:0]         pronto;
    logic                 ocupado;
    logic                 txZera;
    logic                 txCarrega;
    logic                 txDesloca;
    logic                 txConta;
    logic [ASCII_W-1:0]   txDadosAscii;
    logic                 txFim;
    logic [FRAME_BITS-1:0] quadro;
    logic [3:0]           contaBits;
    logic                 saidaSerial;

    int totalChecks = 0;
    int badChecks   = 0;
    int tbCycle     = 0;

    // Reference model: owner, sampling cycle, pointer, latched byte and shifts done.
    bit             modelValid = 1'b0;
    int             mCyc;
    int             mOwn;
    int             mT0;
    int             mPtr;
    int             mShifts;
    logic [ASCII_W-1:0] mAscii;

    int grantLog[$];
    int prontoCycle[$];
    int prontoVal[$];

    tx_serial_7o1_arbitro #(
        .N_REQ         (N),
        .TICKS_PER_BIT (T),
        .TICK_W        (3)
    ) dut (
        .i_clock          (clock),
        .i_reset          (reset),
        .i_req            (req),
        .i_dados          (dados),
        .o_grant          (grant),
        .o_pronto         (pronto),
        .o_ocupado        (ocupado),
        .o_tx_zera        (txZera),
        .o_tx_carrega     (txCarrega),
        .o_tx_desloca     (txDesloca),
        .o_tx_conta       (txConta),
        .o_tx_dados_ascii (txDadosAscii),
        .i_tx_fim         (txFim)
    );

    always #5 clock = ~clock;

    // Behavioural 7O1 transmit datapath driven by the DUT strobes; line is the LSB.
    always @(posedge clock) begin
        if (reset) begin
            quadro    <= '1;
            contaBits <= '0;
        end else begin
            if (txCarrega) begin
                quadro <= {1'b1, ~^txDadosAscii, txDadosAscii, 1'b0, 1'b1};
            end else if (txDesloca) begin
                quadro <= {1'b1, quadro[FRAME_BITS-1:1]};
            end
            if (txZera) begin
                contaBits <= '0;
            end else if (txConta) begin
                contaBits <= contaBits + 4'd1;
            end
        end
    end

    assign txFim       = (contaBits == 4'(FRAME_BITS));
    assign saidaSerial = quadro[0];

    function automatic logic [ASCII_W*N-1:0] randomDados();
        return (ASCII_W*N)'($urandom);
    endfunction

    // Shift k of a frame happens k bit periods after PREPARACAO, for k = 1..11.
    function automatic bit isShift(input int off);
        return (off >= 1 + T) && (off <= 1 + FRAME_BITS * T) && ((off - 1) % T == 0);
    endfunction

    // Line level after s shifts: idle, start, LSB-first data, odd parity, stop, idle.
    function automatic logic lineBit(input int s, input logic [ASCII_W-1:0] b);
        if (s == 0) return 1'b1;
        if (s == 1) return 1'b0;
        if (s <= 8) return b[s-2];
        if (s == 9) return ~^b;
        return 1'b1;
    endfunction

    function automatic int pickWinner(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic int oneHotIdx(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[k]) return k;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h cycle=%0d", tag, observed, expected, tbCycle);
        end
    endtask

    // One clock cycle: drive inputs, compare every output with the model, then advance the model.
    task automatic applyStimulus(input logic rst, input logic [N-1:0] r, input logic [ASCII_W*N-1:0] d);
        int          off;
        int          start;
        logic [31:0] expGrant;
        @(posedge clock);
        #1;
        reset = rst;
        req   = r;
        dados = d;
        tbCycle++;
        @(negedge clock);
        off = (mOwn >= 0) ? (mCyc - mT0) : -1;
        if (modelValid) begin
            expGrant = (mOwn >= 0) ? (32'd1 << mOwn) : 32'd0;
            checkOutput("grant",   32'(grant),        expGrant);
            checkOutput("pronto",  32'(pronto),       (off == FRAME_CYCLES) ? expGrant : 32'd0);
            checkOutput("ocupado", 32'(ocupado),      32'(mOwn >= 0));
            checkOutput("zera",    32'(txZera),       32'(off == 1));
            checkOutput("carrega", 32'(txCarrega),    32'(off == 1));
            checkOutput("desloca", 32'(txDesloca),    32'(isShift(off)));
            checkOutput("conta",   32'(txConta),      32'(isShift(off)));
            checkOutput("ascii",   32'(txDadosAscii), 32'(mAscii));
            checkOutput("linha",   32'(saidaSerial),  32'(lineBit(mShifts, mAscii)));
        end
        if (txCarrega === 1'b1) grantLog.push_back(oneHotIdx(grant));
        if (pronto !== '0) begin
            prontoCycle.push_back(tbCycle);
            prontoVal.push_back(int'(pronto));
        end
        if (rst) begin
            mCyc       = 0;
            mOwn       = -1;
            mPtr       = 0;
            mAscii     = '0;
            mShifts    = FRAME_BITS;
            modelValid = 1'b1;
        end else if (modelValid) begin
            if (mOwn >= 0) begin
                if (isShift(off)) mShifts++;
                if (off == FRAME_CYCLES) begin
`ifndef TX_ARB_PRIORIDADE_FIXA_EN
                    mPtr = (mOwn + 1) % N;
`endif
                    mOwn = -1;
                end
            end else if (mCyc >= 1 && r != '0) begin
`ifdef TX_ARB_PRIORIDADE_FIXA_EN
                start = 0;
`else
                start = mPtr;
`endif
                mOwn    = pickWinner(r, start);
                mT0     = mCyc;
                mAscii  = d[mOwn*ASCII_W +: ASCII_W];
                mShifts = 0;
            end
            mCyc++;
        end
    endtask

    // Two reset cycles plus the INICIAL cycle; the next call lands in ESPERA.
    task automatic resetDut();
        applyStimulus(1'b1, '0, randomDados());
        applyStimulus(1'b1, '0, randomDados());
        applyStimulus(1'b0, '0, randomDados());
        grantLog.delete();
        prontoCycle.delete();
        prontoVal.delete();
    endtask

    initial begin
        logic [ASCII_W*N-1:0] d;
        logic [N-1:0]         r;
        int                   reqCycle;
        int                   expOrder4[5];
        int                   expOrderAlt[4];

`ifdef TX_ARB_PRIORIDADE_FIXA_EN
        expOrder4   = '{0, 0, 0, 0, 0};
        expOrderAlt = '{1, 1, 1, 1};
`else
        expOrder4   = '{0, 1, 2, 3, 0};
        expOrderAlt = '{1, 3, 1, 3};
`endif

        // Idle: no strobes, not busy, line high.
        resetDut();
        repeat (100) applyStimulus(1'b0, '0, randomDados());

        // Single request of 'A' from requester 0.
        d = randomDados();
        d[ASCII_W-1:0] = 7'h41;
        applyStimulus(1'b0, 4'b0001, d);
        reqCycle = tbCycle;
        repeat (55) applyStimulus(1'b0, '0, randomDados());
        checkOutput("single_count", 32'(prontoVal.size()), 32'd1);
        if (prontoVal.size() > 0) begin
            checkOutput("single_pronto", 32'(prontoVal[0]), 32'b0001);
            checkOutput("single_latency", 32'(prontoCycle[0] - reqCycle), 32'd47);
        end

        // Full contention with distinct bytes.
        resetDut();
        d = {7'h44, 7'h43, 7'h42, 7'h41};
        repeat (5 * 48 + 4) applyStimulus(1'b0, 4'b1111, d);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("contention_grant%0d", i),
                        (grantLog.size() > i) ? 32'(grantLog[i]) : 32'hFFFF_FFFF, 32'(expOrder4[i]));
            checkOutput($sformatf("contention_pronto%0d", i),
                        (prontoVal.size() > i) ? 32'(prontoVal[i]) : 32'd0, 32'd1 << expOrder4[i]);
        end

        // Requesters 1 and 3 held together.
        resetDut();
        repeat (4 * 48 + 4) applyStimulus(1'b0, 4'b1010, randomDados());
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("alt_grant%0d", i),
                        (grantLog.size() > i) ? 32'(grantLog[i]) : 32'hFFFF_FFFF, 32'(expOrderAlt[i]));
        end

        // Requester 2 drops its request 10 cycles after grant.
        resetDut();
        applyStimulus(1'b0, 4'b0100, randomDados());
        repeat (10) applyStimulus(1'b0, 4'b0100, randomDados());
        repeat (50) applyStimulus(1'b0, '0, randomDados());
        checkOutput("drop_count", 32'(prontoVal.size()), 32'd1);
        if (prontoVal.size() > 0) begin
            checkOutput("drop_pronto", 32'(prontoVal[0]), 32'b0100);
        end

        // Reset on the 5th shift of requester 2's frame with requester 1 pending.
        resetDut();
        applyStimulus(1'b0, 4'b0100, randomDados());
        repeat (20) applyStimulus(1'b0, 4'b0110, randomDados());
        applyStimulus(1'b1, 4'b0110, randomDados());
        repeat (55) applyStimulus(1'b0, 4'b0110, randomDados());
        checkOutput("abort_first_grant",
                    (grantLog.size() > 0) ? 32'(grantLog[0]) : 32'hFFFF_FFFF, 32'd2);
        checkOutput("abort_restart_grant",
                    (grantLog.size() > 1) ? 32'(grantLog[1]) : 32'hFFFF_FFFF, 32'd1);
        checkOutput("abort_pronto_count", 32'(prontoVal.size()), 32'd1);
        if (prontoVal.size() > 0) begin
            checkOutput("abort_pronto", 32'(prontoVal[0]), 32'b0010);
        end

        // Randomised traffic: held request patterns, changing bytes, rare resets.
        resetDut();
        r = '0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) r = N'($urandom);
            applyStimulus(($urandom_range(0, 499) == 0), r, randomDados());
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
